// File: rtl/draw_board_pkg.sv
// Shared types and constants for the board renderer: cell states, palette
// and the fixed pipeline latency of draw_board.
package board_pkg;

  typedef enum logic [1:0] {
    WATER = 2'd0,
    SHIP  = 2'd1,
    HIT   = 2'd2,
    MISS  = 2'd3
  } cell_state_t;

  localparam logic [11:0] COLOR_WATER = 12'h06C;
  localparam logic [11:0] COLOR_SHIP  = 12'h888;
  localparam logic [11:0] COLOR_HIT   = 12'hF00;
  localparam logic [11:0] COLOR_MISS  = 12'hFFF;
  localparam logic [11:0] COLOR_GRID  = 12'h000;

  localparam int DRAW_BOARD_LATENCY = 3;

  function automatic logic [11:0] cell_color(input logic [1:0] state);
    logic [11:0] color;
    case (cell_state_t'(state))
      WATER:   color = COLOR_WATER;
      SHIP:    color = COLOR_SHIP;
      HIT:     color = COLOR_HIT;
      MISS:    color = COLOR_MISS;
      default: color = COLOR_GRID;
    endcase
    return color;
  endfunction

endpackage

// File: rtl/draw_board_delay.sv
// Parameterised shift register used to carry side-band video signals
// alongside the memory fetch; CLK_DEL must be at least 1.
module delay #(
  parameter int WIDTH   = 8,
  parameter int CLK_DEL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] r_stage [CLK_DEL];

  // shift chain, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CLK_DEL; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= din;
      for (int i = 1; i < CLK_DEL; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign dout = r_stage[CLK_DEL-1];

endmodule

// File: rtl/draw_board.sv
// Renders the game board into the VGA pixel stream: maps each pixel to a
// cell address, fetches its state from board_mem and recolours the pixel.
module draw_board
  import board_pkg::*;
#(
  parameter int X_POS        = 100,
  parameter int Y_POS        = 100,
  parameter int CELL_SIZE    = 32,
  parameter int X_SIZE       = 16,
  parameter int Y_SIZE       = 16,
  parameter int X_ADDR_WIDTH = 4,
  parameter int Y_ADDR_WIDTH = 4,
  parameter int DATA_WIDTH   = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [10:0]                        hcount_in,
  input  logic [10:0]                        vcount_in,
  input  logic                               hsync_in,
  input  logic                               hblnk_in,
  input  logic                               vsync_in,
  input  logic                               vblnk_in,
  input  logic [11:0]                        rgb_in,
  output logic [Y_ADDR_WIDTH+X_ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0]              mem_data,
  output logic [10:0]                        hcount_out,
  output logic [10:0]                        vcount_out,
  output logic                               hsync_out,
  output logic                               hblnk_out,
  output logic                               vsync_out,
  output logic                               vblnk_out,
  output logic [11:0]                        rgb_out
);

  localparam int          CELL_LOG2 = $clog2(CELL_SIZE);
  localparam logic [10:0] CELL_MASK = 11'(CELL_SIZE - 1);
  localparam logic [10:0] X_FIRST   = 11'(X_POS);
  localparam logic [10:0] X_LAST    = 11'(X_POS + X_SIZE * CELL_SIZE - 1);
  localparam logic [10:0] Y_FIRST   = 11'(Y_POS);
  localparam logic [10:0] Y_LAST    = 11'(Y_POS + Y_SIZE * CELL_SIZE - 1);
  localparam int          SB_WIDTH  = 11 + 11 + 4 + 12;

  logic [10:0]             w_x_off;
  logic [10:0]             w_y_off;
  logic [X_ADDR_WIDTH-1:0] w_x_idx;
  logic [Y_ADDR_WIDTH-1:0] w_y_idx;
  logic                    w_in_board;
  logic                    w_is_grid;
  logic [SB_WIDTH-1:0]     w_sb_in;
  logic [SB_WIDTH-1:0]     w_sb_dly;
  logic [10:0]             w_hcount_d2;
  logic [10:0]             w_vcount_d2;
  logic                    w_hsync_d2;
  logic                    w_hblnk_d2;
  logic                    w_vsync_d2;
  logic                    w_vblnk_d2;
  logic [11:0]             w_rgb_d2;
  logic [11:0]             w_rgb_next;

  logic [Y_ADDR_WIDTH+X_ADDR_WIDTH-1:0] r_mem_addr;
  logic r_in_board1;
  logic r_in_board2;
  logic r_is_grid1;
  logic r_is_grid2;

  // Negative offsets left/above the board wrap to large values; the
  // explicit bounds compare rejects them before the index is used.
  assign w_x_off    = hcount_in - X_FIRST;
  assign w_y_off    = vcount_in - Y_FIRST;
  assign w_x_idx    = X_ADDR_WIDTH'(w_x_off >> CELL_LOG2);
  assign w_y_idx    = Y_ADDR_WIDTH'(w_y_off >> CELL_LOG2);
  assign w_in_board = (hcount_in >= X_FIRST) && (hcount_in <= X_LAST) &&
                      (vcount_in >= Y_FIRST) && (vcount_in <= Y_LAST);
  assign w_is_grid  = ((w_x_off & CELL_MASK) == 11'd0) ||
                      ((w_y_off & CELL_MASK) == 11'd0);

  assign w_sb_in = {hcount_in, vcount_in, hsync_in, hblnk_in, vsync_in, vblnk_in, rgb_in};

  delay #(
    .WIDTH   (SB_WIDTH),
    .CLK_DEL (DRAW_BOARD_LATENCY - 1)
  ) u_sideband_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (w_sb_in),
    .dout (w_sb_dly)
  );

  assign {w_hcount_d2, w_vcount_d2, w_hsync_d2, w_hblnk_d2,
          w_vsync_d2, w_vblnk_d2, w_rgb_d2} = w_sb_dly;

  // fetch stage and its qualifier pipeline; address holds outside the board
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_addr  <= '0;
      r_in_board1 <= 1'b0;
      r_in_board2 <= 1'b0;
      r_is_grid1  <= 1'b0;
      r_is_grid2  <= 1'b0;
    end else begin
      if (w_in_board) begin
        r_mem_addr <= {w_y_idx, w_x_idx};
      end else begin
        r_mem_addr <= r_mem_addr;
      end
      r_in_board1 <= w_in_board;
      r_in_board2 <= r_in_board1;
      r_is_grid1  <= w_is_grid;
      r_is_grid2  <= r_is_grid1;
    end
  end

  assign mem_addr = r_mem_addr;

  // colour select; blanking overrides everything
  always_comb begin
    w_rgb_next = w_rgb_d2;
    if (w_hblnk_d2 || w_vblnk_d2) begin
      w_rgb_next = 12'h000;
    end else if (!r_in_board2) begin
      w_rgb_next = w_rgb_d2;
    end else if (r_is_grid2) begin
      w_rgb_next = COLOR_GRID;
    end else begin
      w_rgb_next = cell_color(2'(mem_data));
    end
  end

  // output register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount_out <= 11'd0;
      vcount_out <= 11'd0;
      hsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vsync_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= 12'h000;
    end else begin
      hcount_out <= w_hcount_d2;
      vcount_out <= w_vcount_d2;
      hsync_out  <= w_hsync_d2;
      hblnk_out  <= w_hblnk_d2;
      vsync_out  <= w_vsync_d2;
      vblnk_out  <= w_vblnk_d2;
      rgb_out    <= w_rgb_next;
    end
  end

endmodule

// File: tb/tb_draw_board.sv
// Randomised self-checking bench for draw_board against a pixel-level
// reference model and a 1-cycle registered board memory.
module tb_draw_board;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, hblnk_in, vsync_in, vblnk_in;
  logic [11:0] rgb_in;
  logic [7:0]  mem_addr;
  logic [1:0]  mem_data;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
  logic [11:0] rgb_out;

  logic [1:0]  mem [256];
  logic [37:0] hist [8192];
  logic [7:0]  exp_addr;
  int          cyc;
  int          base;
  int          n_total;
  int          n_bad;

  always #5 clk = ~clk;

  always_ff @(posedge clk) mem_data <= mem[mem_addr];

  draw_board dut (
    .clk        (clk),
    .rst        (rst),
    .hcount_in  (hcount_in),
    .vcount_in  (vcount_in),
    .hsync_in   (hsync_in),
    .hblnk_in   (hblnk_in),
    .vsync_in   (vsync_in),
    .vblnk_in   (vblnk_in),
    .rgb_in     (rgb_in),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .hcount_out (hcount_out),
    .vcount_out (vcount_out),
    .hsync_out  (hsync_out),
    .hblnk_out  (hblnk_out),
    .vsync_out  (vsync_out),
    .vblnk_out  (vblnk_out),
    .rgb_out    (rgb_out)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit on_board(input int h, input int v);
    return (h >= 100) && (h <= 611) && (v >= 100) && (v <= 611);
  endfunction

  function automatic logic [11:0] ref_rgb(input int h, input int v, input bit hb,
                                          input bit vb, input logic [11:0] rgb);
    int xo, yo;
    if (hb || vb) return 12'h000;
    if (!on_board(h, v)) return rgb;
    xo = h - 100;
    yo = v - 100;
    if ((xo % 32 == 0) || (yo % 32 == 0)) return 12'h000;
    case (mem[(yo / 32) * 16 + xo / 32])
      2'd0:    return 12'h06C;
      2'd1:    return 12'h888;
      2'd2:    return 12'hF00;
      default: return 12'hFFF;
    endcase
  endfunction

  task automatic pixel(input int h, input int v, input bit hs, input bit hb,
                       input bit vs, input bit vb, input logic [11:0] rgb);
    logic [37:0] exp_out;
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    hsync_in  = hs;
    hblnk_in  = hb;
    vsync_in  = vs;
    vblnk_in  = vb;
    rgb_in    = rgb;
    hist[cyc] = {11'(h), 11'(v), hs, hb, vs, vb, ref_rgb(h, v, hb, vb, rgb)};
    if (on_board(h, v)) exp_addr = 8'(((v - 100) / 32) * 16 + (h - 100) / 32);
    @(posedge clk);
    #1;
    check_val("mem_addr", {56'd0, mem_addr}, {56'd0, exp_addr});
    exp_out = (cyc - base >= 2) ? hist[cyc - 2] : 38'd0;
    check_val("video_out", {26'd0, hcount_out, vcount_out, hsync_out, hblnk_out,
                            vsync_out, vblnk_out, rgb_out}, {26'd0, exp_out});
    cyc++;
  endtask

  task automatic idle();
    pixel(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h111);
  endtask

  task automatic rand_pixel();
    pixel($urandom_range(60, 660), $urandom_range(60, 660), 1'($urandom),
          ($urandom % 8) == 0, 1'($urandom), ($urandom % 8) == 0, 12'($urandom));
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    cyc     = 0;
    base    = 0;
    exp_addr = 8'd0;
    for (int a = 0; a < 256; a++) mem[a] = 2'($urandom);
    mem[8'h23] = 2'd1;
    mem[8'h10] = 2'd2;
    rst = 1'b1;
    hcount_in = 11'd0; vcount_in = 11'd0;
    hsync_in = 1'b0; hblnk_in = 1'b0; vsync_in = 1'b0; vblnk_in = 1'b0;
    rgb_in = 12'h000;
    #3;
    check_val("reset_state", {18'd0, mem_addr, hcount_out, vcount_out, hsync_out,
                              hblnk_out, vsync_out, vblnk_out, rgb_out}, 64'd0);
    @(posedge clk);
    #2 rst = 1'b0;

    pixel(201, 169, 1'b0, 1'b0, 1'b0, 1'b0, 12'h123);
    check_val("fetch_addr", {56'd0, mem_addr}, 64'h23);
    idle(); idle();
    check_val("fetch_ship", {52'd0, rgb_out}, 64'h888);

    pixel(100, 150, 1'b0, 1'b0, 1'b0, 1'b0, 12'hFFF);
    idle(); idle();
    check_val("grid_line", {52'd0, rgb_out}, 64'h000);

    pixel(99, 150, 1'b0, 1'b0, 1'b0, 1'b0, 12'hABC);
    idle(); idle();
    check_val("left_pass", {52'd0, rgb_out}, 64'hABC);

    pixel(611, 611, 1'b0, 1'b0, 1'b0, 1'b0, 12'h5A5);
    check_val("last_addr", {56'd0, mem_addr}, 64'hFF);
    pixel(612, 611, 1'b0, 1'b0, 1'b0, 1'b0, 12'h5A5);
    idle(); idle();
    check_val("right_pass", {52'd0, rgb_out}, 64'h5A5);

    pixel(300, 300, 1'b0, 1'b1, 1'b0, 1'b0, 12'hFFF);
    idle(); idle();
    check_val("hblank_rgb", {52'd0, rgb_out}, 64'h000);
    check_val("hblank_out", {63'd0, hblnk_out}, 64'd1);

    for (int i = 0; i < 1500; i++) rand_pixel();

    idle(); idle(); idle();
    for (int a = 0; a < 256; a++) mem[a] = 2'(a);
    for (int y = 0; y < 16; y++) begin
      for (int x = 0; x < 16; x++) begin
        pixel(116 + 32 * x, 116 + 32 * y, 1'b0, 1'b0, 1'b0, 1'b0, 12'h777);
      end
    end
    idle(); idle();

    for (int i = 0; i < 4; i++) pixel(300 + i, 300, 1'b1, 1'b0, 1'b1, 1'b0, 12'h321);
    #3 rst = 1'b1;
    #1;
    check_val("async_reset", {18'd0, mem_addr, hcount_out, vcount_out, hsync_out,
                              hblnk_out, vsync_out, vblnk_out, rgb_out}, 64'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    base = cyc;
    exp_addr = 8'd0;
    for (int i = 0; i < 40; i++) rand_pixel();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
